// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter shared by the MIPS32 fetch and data stages.
// Data wins conflicts unless fetch has been refused STARVE_MAX times in a row.
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   if_stall_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1) + 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {
        DATA_PRI,
        FETCH_PRI
    } pri_state_t;

    pri_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rd_if_q, rd_dm_q;
    logic [DW-1:0] if_hold_q, dm_hold_q;
    logic [15:0]   stall_q;

    // Grants are forced low while reset is held so nothing reaches the memory.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && dm_req) begin
                if (state_q == FETCH_PRI) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                dm_gnt = dm_req;
            end
        end
    end

    always_comb begin
        starve_d = '0;
        state_d  = state_q;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end
        case (state_q)
            DATA_PRI:  if (starve_d == STARVE_LIM) state_d = FETCH_PRI;
            FETCH_PRI: if (if_gnt || !if_req)      state_d = DATA_PRI;
            default:   state_d = DATA_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DATA_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign mem_en    = if_gnt | dm_gnt;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = mem_we ? dm_wdata : '0;

    // Response ownership is tracked per port; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_if_q   <= 1'b0;
            rd_dm_q   <= 1'b0;
            if_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            rd_if_q <= if_gnt;
            rd_dm_q <= dm_gnt & ~dm_we;
            if (rd_if_q) if_hold_q <= mem_rdata;
            if (rd_dm_q) dm_hold_q <= mem_rdata;
        end
    end

    assign if_rvalid = rd_if_q;
    assign dm_rvalid = rd_dm_q;
    assign if_rdata  = rd_if_q ? mem_rdata : if_hold_q;
    assign dm_rdata  = rd_dm_q ? mem_rdata : dm_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (if_req && !if_gnt && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign if_stall_cnt = stall_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Randomized scoreboard bench for mips32_mem_arbiter; a second instance with a
// huge starvation limit exercises if_stall_cnt saturation.
module tb_mips32_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   if_stall_cnt;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_stall_cnt(if_stall_cnt)
    );

    // Saturation instance: both ports request forever and fetch never gets priority.
    logic          rst2_n;
    logic          one_s, zero_s;
    logic [AW-1:0] addr0_s;
    logic [DW-1:0] data0_s;
    logic          if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2, mem_en2, mem_we2;
    logic [DW-1:0] if_rdata2, dm_rdata2, mem_wdata2;
    logic [AW-1:0] mem_addr2;
    logic [15:0]   stall2;
    int            cyc2;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(100000)) dut_sat (
        .clk(clk), .rst_n(rst2_n),
        .if_req(one_s), .if_addr(addr0_s), .if_gnt(if_gnt2),
        .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
        .dm_req(one_s), .dm_we(zero_s), .dm_addr(addr0_s), .dm_wdata(data0_s),
        .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(data0_s), .if_stall_cnt(stall2)
    );

    always @(posedge clk) if (rst2_n) cyc2 <= cyc2 + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA500_0000 + DW'(i) * 32'h0000_0111;
    endfunction

    // Memory model: one-cycle read latency, reloaded while reset is held.
    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit            is_if;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    // Reference model: fetch wins a conflict once refused STARVE_MAX times in a row.
    logic [DW-1:0] ref_mem [0:15];
    bit            pend_if, pend_dm, dm_w, read_granted;
    logic [AW-1:0] if_a, dm_a;
    logic [DW-1:0] dm_d;
    int            denied, stall_m;

    task automatic modelReset();
        pend_if = 0; pend_dm = 0; denied = 0; stall_m = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic applyStimulus(input int if_pct, input int dm_pct, input int we_pct);
        int g;
        @(negedge clk);
        if (!pend_if && $urandom_range(99) < if_pct) begin
            pend_if = 1; if_a = AW'($urandom_range(15));
        end
        if (!pend_dm && $urandom_range(99) < dm_pct) begin
            pend_dm = 1; dm_a = AW'($urandom_range(15));
            dm_w = ($urandom_range(99) < we_pct); dm_d = $urandom;
        end
        if_req = pend_if; if_addr = if_a;
        dm_req = pend_dm; dm_we = dm_w; dm_addr = dm_a; dm_wdata = dm_d;
        #1;
        if (pend_if && pend_dm) g = (denied >= STARVE_MAX) ? 1 : 2;
        else if (pend_if)       g = 1;
        else if (pend_dm)       g = 2;
        else                    g = 0;
        checkOutput("if_gnt", if_gnt, g == 1);
        checkOutput("dm_gnt", dm_gnt, g == 2);
        checkOutput("mem_en", mem_en, g != 0);
        checkOutput("mem_we", mem_we, g == 2 && dm_w);
        checkOutput("mem_addr", mem_addr, g == 1 ? if_a : (g == 2 ? dm_a : '0));
        checkOutput("mem_wdata", mem_wdata, (g == 2 && dm_w) ? dm_d : '0);
        checkOutput("if_stall_cnt", if_stall_cnt, stall_m);
        @(posedge clk);
        read_granted = 0;
        if (g == 1) begin
            sb_q.push_back('{1'b1, ref_mem[if_a[3:0]]});
            read_granted = 1;
        end else if (g == 2 && dm_w) begin
            ref_mem[dm_a[3:0]] = dm_d;
        end else if (g == 2) begin
            sb_q.push_back('{1'b0, ref_mem[dm_a[3:0]]});
            read_granted = 1;
        end
        if (pend_if && g != 1) begin
            denied++;
            if (stall_m < 65535) stall_m++;
        end else begin
            denied = 0;
        end
        if (g == 1) pend_if = 0;
        if (g == 2) pend_dm = 0;
    endtask

    // Monitor: every queued read must come back on its own port exactly one cycle later.
    logic [DW-1:0] last_if, last_dm;
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            sb_q.delete();
            last_if = '0;
            last_dm = '0;
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("if_rvalid", if_rvalid, e.is_if);
            checkOutput("dm_rvalid", dm_rvalid, !e.is_if);
            if (e.is_if) begin
                checkOutput("if_rdata", if_rdata, e.data);
                last_if = e.data;
            end else begin
                checkOutput("dm_rdata", dm_rdata, e.data);
                last_dm = e.data;
            end
        end else begin
            checkOutput("if_rvalid_idle", if_rvalid, 1'b0);
            checkOutput("dm_rvalid_idle", dm_rvalid, 1'b0);
            checkOutput("if_rdata_hold", if_rdata, last_if);
            checkOutput("dm_rdata_hold", dm_rdata, last_dm);
        end
    end

    task automatic resetMidAccess();
        int tries = 0;
        read_granted = 0;
        while (!read_granted && tries < 20) begin
            applyStimulus(100, 0, 0);
            tries++;
        end
        checkOutput("reset_setup_read", read_granted, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_if_gnt", if_gnt, 1'b0);
        checkOutput("rst_dm_gnt", dm_gnt, 1'b0);
        checkOutput("rst_mem_en", mem_en, 1'b0);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_if_rvalid", if_rvalid, 1'b0);
        checkOutput("rst_dm_rvalid", dm_rvalid, 1'b0);
        checkOutput("rst_if_rdata", if_rdata, '0);
        checkOutput("rst_dm_rdata", dm_rdata, '0);
        checkOutput("rst_stall", if_stall_cnt, '0);
        modelReset();
        if_req = 0; dm_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 0; rst2_n = 0; cyc2 = 0;
        one_s = 1; zero_s = 0; addr0_s = '0; data0_s = '0;
        if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        if_a = '0; dm_a = '0; dm_d = '0; dm_w = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_en", mem_en, 1'b0);
        checkOutput("reset_stall", if_stall_cnt, '0);
        checkOutput("reset_sat_stall", stall2, '0);
        @(negedge clk);
        rst_n = 1; rst2_n = 1;

        $display("[TB] continuous conflict: expect D,D,D,I pattern");
        repeat (16) applyStimulus(100, 100, 0);
        $display("[TB] random traffic");
        repeat (1500) applyStimulus(60, 60, 40);
        repeat (300) applyStimulus(100, 100, 50);
        $display("[TB] reset during an outstanding read");
        resetMidAccess();
        repeat (12) applyStimulus(100, 100, 0);
        repeat (500) applyStimulus(70, 50, 30);

        @(negedge clk);
        pend_if = 0; pend_dm = 0; if_req = 0; dm_req = 0;
        checkOutput("sat_stall_mid", stall2, (cyc2 > 65535) ? 65535 : cyc2);
        while (cyc2 < 66000) @(negedge clk);
        checkOutput("sat_stall_final", stall2, 16'hFFFF);
        repeat (3) @(negedge clk);
        checkOutput("sat_stall_hold", stall2, 16'hFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
